// File: rtl/mips_pkg.sv
// Shared types and default parameters for the CPU/DMA memory arbiter.
package mips_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/arb_timeout_ctr.sv
// Counts BUSY cycles of one memory access; expired flags the last allowed cycle.
module arb_timeout_ctr
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [7:0] r_count;

    // Count 0 is the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th one.
    assign o_expired = (r_count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU and a DMA requester access to one memory
// port, one access at a time, with an abort after TIMEOUT unanswered cycles.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    arb_state_t    r_state;
    owner_t        r_owner;
    owner_t        r_last_owner;
    owner_t        w_winner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_mem_en;
    logic          r_cpu_gnt, r_cpu_done, r_cpu_err;
    logic          r_dma_gnt, r_dma_done, r_dma_err;
    logic [DW-1:0] r_cpu_rdata, r_dma_rdata;
    logic          w_expired;
    logic          w_busy;

    assign w_busy = (r_state == BUSY);

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (cpu_req && dma_req) begin
            w_winner = (r_last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (cpu_req) begin
            w_winner = OWN_CPU;
        end else begin
            w_winner = OWN_DMA;
        end
    end

    arb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_busy),
        .i_enable (w_busy),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_DMA;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_gnt    <= 1'b0;
            r_dma_done   <= 1'b0;
            r_dma_err    <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_cpu_gnt  <= 1'b0;
            r_dma_gnt  <= 1'b0;
            r_cpu_done <= 1'b0;
            r_dma_done <= 1'b0;
            r_cpu_err  <= 1'b0;
            r_dma_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        r_state      <= BUSY;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_mem_en     <= 1'b1;
                        if (w_winner == OWN_CPU) begin
                            r_cpu_gnt <= 1'b1;
                            r_we      <= cpu_we;
                            r_addr    <= cpu_addr;
                            r_wdata   <= cpu_wdata;
                        end else begin
                            r_dma_gnt <= 1'b1;
                            r_we      <= dma_we;
                            r_addr    <= dma_addr;
                            r_wdata   <= dma_wdata;
                        end
                    end
                end
                BUSY: begin
                    // mem_ready outranks an expiry in the same cycle.
                    if (mem_ready || w_expired) begin
                        r_state  <= DONE;
                        r_mem_en <= 1'b0;
                        if (r_owner == OWN_CPU) begin
                            r_cpu_done <= 1'b1;
                            r_cpu_err  <= !mem_ready;
                            if (!r_we) r_cpu_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            r_dma_done <= 1'b1;
                            r_dma_err  <= !mem_ready;
                            if (!r_we) r_dma_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt   = r_cpu_gnt;
    assign cpu_done  = r_cpu_done;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_gnt   = r_dma_gnt;
    assign dma_done  = r_dma_done;
    assign dma_err   = r_dma_err;
    assign dma_rdata = r_dma_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences for
// round-robin, idle mem_ready and mid-access reset; done pulses are scoreboarded.
module tb_mem_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        cpu_gnt, cpu_done, cpu_err, dma_gnt, dma_done, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ready_at;   // BUSY cycle (1-based) carrying mem_ready; 0 = never
        logic [31:0] mrdata;
        logic        exp_err;
        logic [31:0] exp_rdata;  // owner's rdata after completion
        int          exp_busy;   // cycles with mem_en high
    } vec_t;

    typedef struct packed {
        logic        own_dma;
        logic        err;
        logic [31:0] cpu_rd;
        logic [31:0] dma_rd;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    logic [31:0] m_cpu_rd = '0, m_dma_rd = '0;
    int          n_vec = 0, n_cmp = 0, n_miss = 0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {cpu_gnt, cpu_done, cpu_err, cpu_rdata, dma_gnt, dma_done, dma_err, dma_rdata,
                mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    task automatic sb_push(input logic own_dma, input logic err, input logic [31:0] rd);
        exp_t e;
        if (own_dma) m_dma_rd = rd;
        else         m_cpu_rd = rd;
        e.own_dma = own_dma;
        e.err     = err;
        e.cpu_rd  = m_cpu_rd;
        e.dma_rd  = m_dma_rd;
        sb.push_back(e);
        n_vec++;
    endtask

    // Every done pulse retires the oldest expected completion.
    always @(negedge clk) begin
        if (cpu_done || dma_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {cpu_done, dma_done}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("completion", {cpu_done, cpu_err, dma_done, dma_err, cpu_rdata, dma_rdata},
                      {!e.own_dma, !e.own_dma & e.err, e.own_dma, e.own_dma & e.err,
                       e.cpu_rd, e.dma_rd});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_cpu_rd = '0;
        m_dma_rd = '0;
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int       busy, first_c, done_c;
        logic     gnt_ok, bus_ok;
        logic [1:0] exp_gnt;
        @(posedge clk);
        @(negedge clk);
        if (v.dma) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        sb_push(v.dma, v.exp_err, v.exp_rdata);
        busy = 0; first_c = -1; done_c = -1; gnt_ok = 1'b1; bus_ok = 1'b1;
        for (int c = 0; c < TO + 8 && done_c < 0; c++) begin
            @(posedge clk);
            #1;
            exp_gnt = 2'b00;
            if (mem_en) begin
                busy++;
                if (first_c < 0) first_c = c;
                if (busy == 1) exp_gnt = v.dma ? 2'b10 : 2'b01;
                if ({mem_we, mem_addr, mem_wdata} !== {v.we, v.addr, v.wdata}) bus_ok = 1'b0;
            end
            if ({dma_gnt, cpu_gnt} !== exp_gnt) gnt_ok = 1'b0;
            mem_ready = mem_en && (busy == v.ready_at);
            mem_rdata = mem_ready ? v.mrdata : $urandom();
            if (cpu_done || dma_done) begin
                done_c = c;
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        mem_ready = 1'b0;
        check("gnt_latency", first_c, 0);
        check("gnt_pulse", gnt_ok, 1'b1);
        check("mem_bus", bus_ok, 1'b1);
        check("busy_cycles", busy, v.exp_busy);
        check("done_cycle", done_c, v.exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_miss=%0d", n_miss);
        $fatal(1);
    end

    initial begin
        int   ng, nd, busy;
        logic flag;
        logic g_own[4];
        int   g_cyc[4];

        //            dma   we    addr          wdata         rdy mrdata        err   exp_rdata     busy
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        1,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4,  32'h0,        1'b0, 32'h0,        4};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        2,  32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 2};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 3,  32'h0,        1'b0, 32'hDEAD_BEEF, 3};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,        0,  32'h0,        1'b1, 32'h0,        TO};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0,        TO, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, TO};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0108, 32'h55AA_55AA, 0,  32'h0,        1'b1, 32'hA5A5_0001, TO};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0050, 32'h0,        15, 32'h1111_2222, 1'b0, 32'h1111_2222, 15};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_010C, 32'h0,        1,  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_0054, 32'h0,        1,  32'h0,        1'b0, 32'h0,        1};

        do_reset();
        check("reset_state", all_outs(), '0);

        // Both requesters held high after reset: CPU, DMA, CPU, DMA, three cycles apart.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
        sb_push(1'b0, 1'b0, 32'hF0F0_0200);
        sb_push(1'b1, 1'b0, 32'hF0F0_0300);
        sb_push(1'b0, 1'b0, 32'hF0F0_0200);
        sb_push(1'b1, 1'b0, 32'hF0F0_0300);
        ng = 0; nd = 0;
        for (int c = 1; c <= 40 && nd < 4; c++) begin
            @(posedge clk);
            #1;
            if (cpu_gnt || dma_gnt) begin
                if (ng < 4) begin
                    g_own[ng] = dma_gnt;
                    g_cyc[ng] = c;
                end
                ng++;
            end
            mem_ready = mem_en;
            mem_rdata = mem_addr ^ 32'hF0F0_0000;
            if (cpu_done || dma_done) begin
                nd++;
                if (nd == 4) begin
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        check("rr_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng)
                check($sformatf("rr_grant%0d", i), {g_own[i], g_cyc[i]}, {1'(i & 1), 32'(1 + 3 * i)});
        end

        do_reset();
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // mem_ready with garbage data outside BUSY must change nothing.
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        flag = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_en || cpu_done || dma_done || cpu_gnt || dma_gnt) flag = 1'b1;
        end
        mem_ready = 1'b0;
        check("idle_ready_ignored", flag, 1'b0);
        check("idle_rdata_kept", {cpu_rdata, dma_rdata}, {m_cpu_rd, m_dma_rd});

        // Reset in the second BUSY cycle aborts the access without a done pulse.
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        busy = 0;
        for (int c = 0; c < 8 && busy < 2; c++) begin
            @(posedge clk);
            #1;
            if (mem_en) busy++;
        end
        check("rst_busy_reached", busy, 2);
        reset = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", all_outs(), '0);
        reset = 1'b1;
        m_cpu_rd = '0;
        m_dma_rd = '0;
        flag = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (mem_en || cpu_done || dma_done || cpu_gnt || dma_gnt) flag = 1'b1;
        end
        check("rst_no_done", flag, 1'b0);
        run_vec('{1'b0, 1'b0, 32'h84, 32'h0, 1, 32'h0000_0077, 1'b0, 32'h0000_0077, 1});

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
